deframer: RTL and testbench

// - Receive-side counterpart of the byte framer: consumes a framed, escaped byte stream and emits

---
 rtl/deframer_if.sv | 16 +
 rtl/deframer.sv | 178 +++++++++++++++++
 tb/tb_deframer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/deframer_if.sv
// Byte-wide AXI4-Stream style link used on both sides of the deframer.
//   tvalid/tready : handshake
//   tdata         : byte
//   tlast         : last byte of packet
//   tuser         : packet error flag (meaningful on the tlast beat only)
// master drives the beat, slave drives tready.
interface deframer_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;
  logic       tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/deframer.sv
// deframer: strips START/STOP delimiters and ESCAPE sequences from a framed byte
// stream and emits the payload as packets, with tlast on the final payload byte
// and tuser set on the tlast beat of an aborted frame.
//
// Ports
//   aclk        : clock
//   areset      : synchronous reset, active-high
//   target      : framed byte stream in (slave modport; tlast/tuser ignored)
//   initiator   : payload stream out (master modport), single register stage
//   frame_count : good frames, saturating (only with DEFRAMER_STATS_EN)
//   error_count : errored frames, saturating (only with DEFRAMER_STATS_EN)
//
// Build option: define DEFRAMER_STATS_EN to add the frame/error counters.
//
// state | meaning
// ------+--------------------------------------------------------------
// HUNT  | outside a frame, waiting for START; all other bytes dropped
// RUN   | inside a frame, next byte is literal / delimiter / ESCAPE
// ESC   | previous byte was ESCAPE; next byte is decoded with ESC_XOR
module deframer #(
  parameter logic [7:0] START_BYTE  = 8'h7D,
  parameter logic [7:0] STOP_BYTE   = 8'h7E,
  parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
  parameter logic [7:0] ESC_XOR     = 8'h20
) (
  input  logic        aclk,
  input  logic        areset,
  deframer_if.slave   target,
  deframer_if.master  initiator
`ifdef DEFRAMER_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
`endif
);

  typedef enum logic [1:0] {HUNT, RUN, ESC} state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic       out_vld_q;
  logic [7:0] out_data_q;
  logic       out_last_q;
  logic       out_user_q;

  logic       accept;
  logic       is_start, is_stop, is_esc;
  logic [7:0] data_byte;
  logic       load_beat;
  logic       beat_last;
  logic       beat_user;
  logic       frame_good;
  logic       frame_bad;

  // Input is taken only when the output register can accept a new beat, so a
  // stalled beat never gets overwritten.
  assign target.tready = !out_vld_q || initiator.tready;
  assign accept        = target.tvalid && target.tready;

  assign is_start  = (target.tdata == START_BYTE);
  assign is_stop   = (target.tdata == STOP_BYTE);
  assign is_esc    = (target.tdata == ESCAPE_BYTE);
  assign data_byte = (state_q == ESC) ? (target.tdata ^ ESC_XOR) : target.tdata;

  assign initiator.tvalid = out_vld_q;
  assign initiator.tdata  = out_data_q;
  assign initiator.tlast  = out_last_q;
  assign initiator.tuser  = out_user_q;

  // State and datapath registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= HUNT;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= 8'h00;
      out_last_q <= 1'b0;
      out_user_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      if (load_beat) begin
        out_vld_q  <= 1'b1;
        out_data_q <= hold_q;
        out_last_q <= beat_last;
        out_user_q <= beat_user;
      end else if (out_vld_q && initiator.tready) begin
        out_vld_q  <= 1'b0;
        out_last_q <= 1'b0;
        out_user_q <= 1'b0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        HUNT: if (is_start) state_d = RUN;
        RUN: begin
          if (is_stop)     state_d = HUNT;
          else if (is_esc) state_d = ESC;
        end
        ESC: begin
          if (is_stop) state_d = HUNT;
          else         state_d = RUN;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output / action logic. The held byte is only released once the following
  // input byte is known, since that byte decides its tlast/tuser tag.
  always_comb begin
    load_beat  = 1'b0;
    beat_last  = 1'b0;
    beat_user  = 1'b0;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (accept) begin
      case (state_q)
        HUNT: begin
          if (is_start) hold_vld_d = 1'b0;
        end
        RUN, ESC: begin
          if (is_start) begin
            // Abort: a frame that never carried payload still counts as an error.
            load_beat  = hold_vld_q;
            beat_last  = 1'b1;
            beat_user  = 1'b1;
            frame_bad  = 1'b1;
            hold_vld_d = 1'b0;
          end else if (is_stop) begin
            load_beat  = hold_vld_q;
            beat_last  = 1'b1;
            beat_user  = (state_q == ESC);
            frame_good = (state_q == RUN) && hold_vld_q;
            frame_bad  = (state_q == ESC);
            hold_vld_d = 1'b0;
          end else if (is_esc && (state_q == RUN)) begin
            hold_vld_d = hold_vld_q;
          end else begin
            load_beat  = hold_vld_q;
            hold_d     = data_byte;
            hold_vld_d = 1'b1;
          end
        end
        default: hold_vld_d = 1'b0;
      endcase
    end
  end

`ifdef DEFRAMER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] error_cnt_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_cnt_q <= 16'h0000;
      error_cnt_q <= 16'h0000;
    end else begin
      if (frame_good && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (frame_bad && (error_cnt_q != 16'hFFFF))  error_cnt_q <= error_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign error_count = error_cnt_q;
`endif

endmodule

// File: tb/tb_deframer.sv
module tb_deframer;

  logic aclk = 1'b0;
  logic areset;

  deframer_if tgt ();
  deframer_if ini ();

`ifdef DEFRAMER_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] error_count;
`endif

  deframer dut (
    .aclk      (aclk),
    .areset    (areset),
    .target    (tgt.slave),
    .initiator (ini.master)
`ifdef DEFRAMER_STATS_EN
    ,
    .frame_count (frame_count),
    .error_count (error_count)
`endif
  );

  always #5 aclk = ~aclk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  logic       got_user[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  logic       exp_user[$];

  bit rand_ready     = 1'b0;
  bit hold_ready_low = 1'b0;

  // Output monitor: a beat counts when it is presented with ready, ahead of the
  // edge that completes the handshake.
  always @(negedge aclk) begin
    if (areset === 1'b0 && ini.tvalid === 1'b1 && ini.tready === 1'b1) begin
      got_data.push_back(ini.tdata);
      got_last.push_back(ini.tlast);
      got_user.push_back(ini.tuser);
    end
  end

  initial begin
    ini.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (rand_ready) ini.tready = 1'($urandom_range(0, 1));
      else            ini.tready = !hold_ready_low;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit done;
    done       = 1'b0;
    tgt.tvalid = 1'b1;
    tgt.tdata  = b;
    for (int i = 0; i < 500; i++) begin
      @(negedge aclk);
      if (tgt.tready === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    if (done) begin
      @(posedge aclk);
      #1;
    end
    tgt.tvalid = 1'b0;
    if (!done) check($sformatf("send_timeout_%02h", b), 32'd0, 32'd1);
  endtask

  task automatic drain();
    int idle;
    idle = 0;
    for (int i = 0; i < 2000 && idle < 4; i++) begin
      @(negedge aclk);
      if (ini.tvalid === 1'b1) idle = 0;
      else                     idle++;
    end
    if (idle < 4) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic l, input logic u);
    exp_data.push_back(d);
    exp_last.push_back(l);
    exp_user.push_back(u);
  endtask

  task automatic clear_q();
    got_data.delete(); got_last.delete(); got_user.delete();
    exp_data.delete(); exp_last.delete(); exp_user.delete();
  endtask

  task automatic compare_beats(input string tag);
    int n;
    check($sformatf("%s_count", tag), 32'(got_data.size()), 32'(exp_data.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
      check($sformatf("%s_user%0d", tag, i), 32'(got_user[i]), 32'(exp_user[i]));
    end
    clear_q();
  endtask

  initial begin
    logic [7:0] p;

    areset     = 1'b1;
    tgt.tvalid = 1'b0;
    tgt.tdata  = 8'h00;
    tgt.tlast  = 1'b0;
    tgt.tuser  = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", 32'(ini.tvalid), 32'd0);
    check("rst_tdata",  32'(ini.tdata),  32'd0);
    check("rst_tlast",  32'(ini.tlast),  32'd0);
    check("rst_tuser",  32'(ini.tuser),  32'd0);
    check("rst_tready", 32'(tgt.tready), 32'd1);
`ifdef DEFRAMER_STATS_EN
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_error_count", 32'(error_count), 32'd0);
`endif
    @(posedge aclk);
    #1 areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Basic frame
    clear_q();
    send(8'h7D); send(8'h01); send(8'h02); send(8'h03); send(8'h7E);
`ifdef DEFRAMER_STATS_EN
    check("t1_frame_count_next_cycle", 32'(frame_count), 32'd1);
    check("t1_error_count", 32'(error_count), 32'd0);
`endif
    drain();
    exp_beat(8'h01, 0, 0); exp_beat(8'h02, 0, 0); exp_beat(8'h03, 1, 0);
    compare_beats("t1");

    // Escaped delimiters as payload
    send(8'h7D); send(8'h7F); send(8'h5D); send(8'h7F); send(8'h5E);
    send(8'h7F); send(8'h5F); send(8'h7E);
    drain();
    exp_beat(8'h7D, 0, 0); exp_beat(8'h7E, 0, 0); exp_beat(8'h7F, 1, 0);
    compare_beats("t2");

    // Junk before START and an empty frame are dropped
    send(8'h55); send(8'h7E); send(8'h7D); send(8'h7E);
    send(8'h7D); send(8'hAA); send(8'h7E);
    drain();
    exp_beat(8'hAA, 1, 0);
    compare_beats("t3");
`ifdef DEFRAMER_STATS_EN
    check("t3_frame_count", 32'(frame_count), 32'd3);
`endif

    // START inside a frame aborts it
    send(8'h7D); send(8'h11); send(8'h22); send(8'h7D); send(8'h33); send(8'h7E);
    drain();
    exp_beat(8'h11, 0, 0); exp_beat(8'h22, 1, 1); exp_beat(8'h33, 1, 0);
    compare_beats("t4");
`ifdef DEFRAMER_STATS_EN
    check("t4_frame_count", 32'(frame_count), 32'd4);
    check("t4_error_count", 32'(error_count), 32'd1);
`endif

    // ESCAPE followed by STOP is an error and returns to HUNT (01 7E then dropped)
    send(8'h7D); send(8'h44); send(8'h7F); send(8'h7E);
`ifdef DEFRAMER_STATS_EN
    check("t5_error_count_next_cycle", 32'(error_count), 32'd2);
`endif
    send(8'h01); send(8'h7E);
    drain();
    exp_beat(8'h44, 1, 1);
    compare_beats("t5");
`ifdef DEFRAMER_STATS_EN
    check("t5_frame_count", 32'(frame_count), 32'd4);
`endif

    // Output stall blocks input
    hold_ready_low = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    send(8'h7D); send(8'hA1); send(8'hA2);
    tgt.tvalid = 1'b1;
    tgt.tdata  = 8'hA3;
    repeat (4) @(negedge aclk);
    check("t6_stall_tready", 32'(tgt.tready), 32'd0);
    check("t6_stall_tvalid", 32'(ini.tvalid), 32'd1);
    check("t6_stall_tdata",  32'(ini.tdata),  32'hA1);
    hold_ready_low = 1'b0;
    send(8'hA3); send(8'h7E);
    drain();
    exp_beat(8'hA1, 0, 0); exp_beat(8'hA2, 0, 0); exp_beat(8'hA3, 1, 0);
    compare_beats("t6");

    // 100-byte frame under random backpressure, delimiter values escaped
    rand_ready = 1'b1;
    send(8'h7D);
    for (int i = 0; i < 100; i++) begin
      p = 8'((i * 7 + 8'h70) & 8'hFF);
      if (p == 8'h7D || p == 8'h7E || p == 8'h7F) begin
        send(8'h7F);
        send(p ^ 8'h20);
      end else begin
        send(p);
      end
      exp_beat(p, (i == 99), 1'b0);
    end
    send(8'h7E);
    drain();
    rand_ready = 1'b0;
    compare_beats("t7");
`ifdef DEFRAMER_STATS_EN
    check("t7_frame_count", 32'(frame_count), 32'd6);
`endif

    // Reset mid-frame discards the held byte
    repeat (2) @(posedge aclk);
    #1;
    send(8'h7D); send(8'h01); send(8'h02);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("t8_rst_tvalid", 32'(ini.tvalid), 32'd0);
`ifdef DEFRAMER_STATS_EN
    check("t8_rst_frame_count", 32'(frame_count), 32'd0);
    check("t8_rst_error_count", 32'(error_count), 32'd0);
`endif
    @(posedge aclk);
    #1 areset = 1'b0;
    send(8'h7D); send(8'h09); send(8'h7E);
    drain();
    exp_beat(8'h01, 0, 0); exp_beat(8'h09, 1, 0);
    compare_beats("t8");
`ifdef DEFRAMER_STATS_EN
    check("t8_frame_count", 32'(frame_count), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
